pcnt_pulse_gen: RTL and testbench
=================================

Name: pcnt_pulse_gen

Overview:
- Programmable pulse-train generator. It is the stimulus-side counterpart of the pulse counter tile.
- It drives the counter's event and direction inputs with a burst of N pulses of programmable period and high time.
- It sits in the same datapath logic-block region as the counter and shares that block's clock and reset.
- Its outputs connect straight to a counter's event_i and up_down_i inputs.

Parameters:
- CNT_W, 16, width of the pulse-count field and of the internal pulse counter.
- DIV_W, 16, width of the period and high-time fields and of the internal phase timer.

Ports:
- pgen_clk_i  input  1  block clock.
- pgen_rst_i  input  1  reset. Asynchronous, active-high. This is fixed.
- pgen_start_i  input  1  level-sampled start request. Acted on only in IDLE.
- pgen_stop_i  input  1  level-sampled abort request.
- pgen_dir_i  input  1  direction to present during the burst (1 = up).
- pgen_count_i  input  CNT_W  pulses per burst. 0 = continuous.
- pgen_period_i  input  DIV_W  clocks per pulse period (P).
- pgen_high_i  input  DIV_W  clocks event is high per period (H).
- pgen_event_o  output  1  registered pulse train.
- pgen_up_down_o  output  1  registered direction. Held for the whole burst.
- pgen_busy_o  output  1  high while a burst is in progress.
- pgen_done_o  output  1  one-cycle pulse on normal burst completion.

Behaviour:
- Reset: while pgen_rst_i=1, all outputs are 0, the FSM is in IDLE, and all counters are 0. This takes effect without a clock edge.
- FSM states: IDLE, HIGH, LOW.
- IDLE -> HIGH:
  - Condition: pgen_start_i=1 and pgen_stop_i=0 at clock edge t.
  - Latch count, P, H and dir.
  - Outputs from cycle t+1: event_o=1, busy_o=1, up_down_o=dir.
- Clamping is applied at latch time:
  - P<2 becomes P=2.
  - H=0 becomes H=1.
  - H>=P becomes H=P-1.
- HIGH lasts exactly H cycles, then the FSM moves to LOW.
- LOW lasts exactly P-H cycles with event_o=0. At the end of LOW:
  - If the pulse counter has reached count (and count is not 0): go to IDLE. In that first IDLE cycle, done_o=1 and busy_o=0.
  - Otherwise: increment the pulse counter and go to HIGH.
- Timing for a burst started at edge t with N>0:
  - event_o is high in cycles t+1+kP .. t+kP+H, for k = 0..N-1.
  - busy_o is high in cycles t+1 .. t+NP.
  - done_o is high in cycle t+NP+1 only.
- count=0: pulses repeat indefinitely until stop. done_o is never asserted.
- Stop, sampled in HIGH or LOW:
  - Next cycle: FSM in IDLE, event_o=0, busy_o=0.
  - done_o is not asserted.
  - up_down_o keeps its last value.
- start and stop both high in IDLE: stop wins and the FSM stays in IDLE.
- start while busy is ignored. Config inputs are ignored while busy; only the latched copy is used.
- up_down_o changes only on the IDLE->HIGH transition or on reset.
- The pulse counter and the phase timer do not wrap. The comparisons are equality-based against the latched values.
- Reset mid-burst: the burst is abandoned and no done_o is produced.

Optional Feature:
- Macro: PCNT_PULSE_GEN_SENT_CNT_EN.
- When defined, an extra output pgen_sent_o [CNT_W] is present:
  - Counts pulses whose HIGH phase has started in the current or most recent burst.
  - Increments in the cycle event_o rises.
  - Cleared to 0 on the IDLE->HIGH transition (then immediately reads 1) and on reset.
  - Holds its value in IDLE.
  - In continuous mode it saturates at all-ones.
- When not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic burst: P=4, H=2, count=3, dir=1, start pulsed at edge 0.
  - event_o pattern is 1100 repeated over cycles 1-12.
  - busy_o is high in cycles 1-12.
  - done_o is high in cycle 13 only.
  - up_down_o=1 from cycle 1.
- Clamping: P=1, H=0, count=2.
  - Behaves as P=2, H=1: event_o = 1,0,1,0 in cycles 1-4, done_o in cycle 5.
  - Separate case, H=9 with P=4: event_o = 1110 per period.
- Continuous with abort: count=0, P=3, H=1, stop asserted at edge 10.
  - Before the stop: event_o = 100 repeating.
  - From cycle 11: event_o=0 and busy_o=0, with no done_o.
- Arbitration:
  - start and stop both high in IDLE: FSM stays IDLE, all outputs 0.
  - start with different config mid-burst: ignored, and the original pattern completes unchanged.
- Async reset: assert pgen_rst_i between clock edges during HIGH.
  - event_o, busy_o and up_down_o go to 0 immediately.
  - After release, a new start works normally.
- With PCNT_PULSE_GEN_SENT_CNT_EN defined, repeat the basic burst.
  - pgen_sent_o reads 1, 2, 3 in cycles 1, 5, 9.
  - It holds 3 after done.
  - It reads 1 again in the first cycle of the next burst.

Source files
------------

// File: rtl/pcnt_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : pcnt_pulse_gen
// Description : Programmable pulse-train generator driving a pulse counter's
//               event/direction inputs with a burst of N pulses of period P
//               and high time H. Optional pulse-sent counter output is enabled
//               by defining PCNT_PULSE_GEN_SENT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pcnt_pulse_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             pgen_clk_i,
    input  logic             pgen_rst_i,
    input  logic             pgen_start_i,
    input  logic             pgen_stop_i,
    input  logic             pgen_dir_i,
    input  logic [CNT_W-1:0] pgen_count_i,
    input  logic [DIV_W-1:0] pgen_period_i,
    input  logic [DIV_W-1:0] pgen_high_i,
    output logic             pgen_event_o,
    output logic             pgen_up_down_o,
    output logic             pgen_busy_o,
    output logic             pgen_done_o
`ifdef PCNT_PULSE_GEN_SENT_CNT_EN
    ,
    output logic [CNT_W-1:0] pgen_sent_o
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HIGH = 2'd1;
    localparam logic [1:0] c_LOW  = 2'd2;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_high_len;
    logic [DIV_W-1:0] r_low_len;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_pulse;
    logic             r_event;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;

    logic [DIV_W-1:0] w_period;
    logic [DIV_W-1:0] w_high;
    logic [DIV_W-1:0] w_low;
    logic [CNT_W-1:0] w_pulse_inc;
    logic             w_last;

    // Clamp so every period has at least one high and one low cycle.
    assign w_period = (pgen_period_i < DIV_W'(2)) ? DIV_W'(2) : pgen_period_i;
    assign w_high   = (pgen_high_i == '0)        ? DIV_W'(1) :
                      (pgen_high_i >= w_period)  ? (w_period - DIV_W'(1)) :
                                                   pgen_high_i;
    assign w_low    = w_period - w_high;

    // Pulse index saturates so continuous mode never wraps.
    assign w_pulse_inc = (r_pulse == '1) ? r_pulse : (r_pulse + CNT_W'(1));
    assign w_last      = (r_count != '0) && (r_pulse == r_count);

    always_ff @(posedge pgen_clk_i or posedge pgen_rst_i) begin
        if (pgen_rst_i) begin
            r_state    <= c_IDLE;
            r_phase    <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_count    <= '0;
            r_pulse    <= '0;
            r_event    <= 1'b0;
            r_dir      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (pgen_start_i && !pgen_stop_i) begin
                        r_state    <= c_HIGH;
                        r_phase    <= DIV_W'(1);
                        r_high_len <= w_high;
                        r_low_len  <= w_low;
                        r_count    <= pgen_count_i;
                        r_pulse    <= CNT_W'(1);
                        r_dir      <= pgen_dir_i;
                        r_event    <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                c_HIGH: begin
                    if (pgen_stop_i) begin
                        r_state <= c_IDLE;
                        r_phase <= '0;
                        r_event <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_phase == r_high_len) begin
                        r_state <= c_LOW;
                        r_phase <= DIV_W'(1);
                        r_event <= 1'b0;
                    end else begin
                        r_phase <= r_phase + DIV_W'(1);
                    end
                end
                c_LOW: begin
                    if (pgen_stop_i) begin
                        r_state <= c_IDLE;
                        r_phase <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_phase == r_low_len) begin
                        if (w_last) begin
                            r_state <= c_IDLE;
                            r_phase <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_HIGH;
                            r_phase <= DIV_W'(1);
                            r_pulse <= w_pulse_inc;
                            r_event <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_phase <= '0;
                    r_event <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pgen_event_o   = r_event;
    assign pgen_up_down_o = r_dir;
    assign pgen_busy_o    = r_busy;
    assign pgen_done_o    = r_done;

`ifdef PCNT_PULSE_GEN_SENT_CNT_EN
    // The running pulse index doubles as the sent count: it holds in IDLE.
    assign pgen_sent_o = r_pulse;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcnt_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcnt_pulse_gen
// Description : Scoreboard bench for pcnt_pulse_gen driven by directed,
//               hand-computed per-cycle vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcnt_pulse_gen;

    localparam int CNT_W = 16;
    localparam int DIV_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] high;
    logic             ev_o;
    logic             ud_o;
    logic             busy_o;
    logic             done_o;
`ifdef PCNT_PULSE_GEN_SENT_CNT_EN
    logic [CNT_W-1:0] sent_o;
`endif

    pcnt_pulse_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .pgen_clk_i     (clk),
        .pgen_rst_i     (rst),
        .pgen_start_i   (start),
        .pgen_stop_i    (stop),
        .pgen_dir_i     (dir),
        .pgen_count_i   (count),
        .pgen_period_i  (period),
        .pgen_high_i    (high),
        .pgen_event_o   (ev_o),
        .pgen_up_down_o (ud_o),
        .pgen_busy_o    (busy_o),
        .pgen_done_o    (done_o)
`ifdef PCNT_PULSE_GEN_SENT_CNT_EN
        ,
        .pgen_sent_o    (sent_o)
`endif
    );

    typedef struct {
        logic ev;
        logic ud;
        logic bs;
        logic dn;
        int   sent;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   base_p, base_h, base_n, base_dir;
    int   alt_p, alt_h, alt_n, alt_dir;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the current cycle's outputs against the queued entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("event",   int'(ev_o),   int'(e.ev));
                chk("up_down", int'(ud_o),   int'(e.ud));
                chk("busy",    int'(busy_o), int'(e.bs));
                chk("done",    int'(done_o), int'(e.dn));
`ifdef PCNT_PULSE_GEN_SENT_CNT_EN
                if (e.sent >= 0) chk("sent", int'(sent_o), e.sent);
`endif
            end
        end
    end

    function automatic logic bit_at(input string s, input int i);
        if (i >= s.len()) return 1'b0;
        return (s.getc(i) == 8'h31);
    endfunction

    // One row per cycle: inputs sampled at the edge ending the cycle,
    // expected outputs are those visible during the cycle.
    task automatic run_vec(input string st, input string sp, input string rs,
                           input string cf, input string ev, input string ud,
                           input string bs, input string dn, input string sn);
        exp_t e;
        for (int i = 0; i < st.len(); i++) begin
            start = bit_at(st, i);
            stop  = bit_at(sp, i);
            if (bit_at(cf, i)) begin
                period = DIV_W'(alt_p); high = DIV_W'(alt_h);
                count  = CNT_W'(alt_n); dir  = alt_dir[0];
            end else begin
                period = DIV_W'(base_p); high = DIV_W'(base_h);
                count  = CNT_W'(base_n); dir  = base_dir[0];
            end
            if (!bit_at(rs, i)) rst = 1'b0;
            e.ev   = bit_at(ev, i);
            e.ud   = bit_at(ud, i);
            e.bs   = bit_at(bs, i);
            e.dn   = bit_at(dn, i);
            e.sent = (i < sn.len()) ? (int'(sn.getc(i)) - 48) : -1;
            sb.push_back(e);
            if (bit_at(rs, i) && !rst) begin
                #1 rst = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        count = '0; period = '0; high = '0;
        alt_p = 0; alt_h = 0; alt_n = 0; alt_dir = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic burst: P=4 H=2 N=3 up.
        base_p = 4; base_h = 2; base_n = 3; base_dir = 1;
        run_vec("100000000000000", "", "", "",
                "011001100110000", "011111111111111",
                "011111111111100", "000000000000010",
                "011112222333333");

        // Clamping P=1 H=0 -> P=2 H=1.
        base_p = 1; base_h = 0; base_n = 2; base_dir = 0;
        run_vec("1000000", "", "", "",
                "0101000", "1000000", "0111100", "0000010", "3112222");

        // Clamping H=9 with P=4 -> H=3.
        base_p = 4; base_h = 9; base_n = 2; base_dir = 1;
        run_vec("10000000000", "", "", "",
                "01110111000", "01111111111", "01111111100",
                "00000000010", "21111222222");

        // Continuous P=3 H=1 with stop at edge 10.
        base_p = 3; base_h = 1; base_n = 0; base_dir = 0;
        run_vec("1000000000000", "0000000000100", "", "",
                "0100100100100", "1000000000000", "0111111111100",
                "0000000000000", "2111222333444");

        // Start and stop together in IDLE: stop wins.
        base_p = 4; base_h = 2; base_n = 3; base_dir = 1;
        run_vec("110", "110", "", "",
                "000", "000", "000", "000", "444");

        // Start with different config mid-burst is ignored.
        base_p = 4; base_h = 1; base_n = 2; base_dir = 1;
        alt_p = 2; alt_h = 1; alt_n = 5; alt_dir = 0;
        run_vec("10010000000", "", "", "00011111111",
                "01000100000", "01111111111", "01111111100",
                "00000000010", "41111222222");

        // Async reset mid-HIGH, then a fresh burst.
        base_p = 4; base_h = 2; base_n = 3; base_dir = 1;
        run_vec("1000100000000000000", "", "0011000000000000000", "",
                "0100011001100110000", "1100011111111111111",
                "0100011111111111100", "0000000000000000010",
                "2100011112222333333");

        @(negedge clk);
        chk("queue_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
